sec_bcd_display: RTL
====================

# sec_bcd_display

Four-digit decimal seconds counter and multiplexed 7-segment driver. Sits directly downstream of the 1-second tick generator: it consumes that block's one-cycle `enable` pulse, accumulates elapsed seconds as 4-digit BCD (0000–9999), and time-multiplexes the digits onto a common-segment 4-digit display. Leading zeros are blanked, and a one-cycle anode dead time is inserted at each digit change to suppress ghosting.

## Interface
- `CLK_FREQ`, 125_000_000: system clock frequency in Hz.
- `SCAN_HZ`, 1000: per-digit refresh rate in Hz. `SCAN_DIV = CLK_FREQ / (4*SCAN_HZ)` must be ≥ 2.

- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `TICK`  in  1  one-cycle pulse from the 1-second generator; one pulse means one count.
- `RUN`  in  1  count enable. `TICK` is ignored while `RUN`=0.
- `CLR`  in  1  synchronous clear of the count.
- `Count`  out  16  BCD count; `Count[3:0]` is the ones digit.
- `Carry`  out  1  one-cycle pulse on wrap 9999→0000.
- `Anode`  out  4  digit enable, active-high, one-hot or all-zero; bit 0 is the ones digit.
- `Segment`  out  8  segment pattern, active-high; bit 7 is the decimal point and is always 0.

## Operation
- All outputs are registered.
- While `RST`=0: `Count`=16'h0000, `Carry`=0, `Anode`=4'b0000, `Segment`=8'h00. The scan index and prescaler are also 0.
- Reset is asserted asynchronously at any point, including mid-scan or mid-count. It is released synchronously by the external reset path.
- Count path, evaluated each cycle in priority order:
  - `CLR`=1: `Count`←0000, `Carry`←0. This applies even if `TICK` is high in the same cycle.
  - else `TICK`&`RUN`: BCD increment. A digit that reaches 9 becomes 0 and carries into the next digit.
  - At 9999 the increment gives 0000 and `Carry`←1 for exactly one cycle.
  - otherwise: hold, `Carry`←0.
- BCD rule: no digit ever holds a value above 9. Binary-to-BCD conversion is not used.
- Scan path:
  - Prescaler `pre` counts 0..SCAN_DIV-1 and wraps.
  - When `pre`=SCAN_DIV-1, the scan index `idx` advances 0→1→2→3→0.
- Anode register:
  - 0000 when `pre`=0 (dead cycle).
  - otherwise one-hot(`idx`).
- Segment register:
  - 8'h00 when `pre`=0.
  - otherwise the decoded digit `idx`, with blanking applied.
- Decode table for values 0–9 (standard team encoding): 3F, 06, 5B, 4F, 66, 6D, 7D, 27, 7F, 6F. Any other value decodes to 00; this cannot occur in a legal state.
- Leading-zero blanking:
  - Digit k is blanked (`Segment`=00) when k>0 and all digits k..3 are 0.
  - Digit 0 is never blanked.
  - An interior zero, for example the tens digit of 105, is displayed.
- Blanked digits still receive their anode time slot, so the refresh period is constant.

## Timing
- `Count` and `Carry` update on the edge after the `TICK` cycle (latency 1).
- `Segment`/`Anode` are registered from `pre`/`idx`/`Count`. A count change appears on `Segment` one cycle after `Count` changes, provided that digit is the one being scanned; otherwise it appears at that digit's next slot.
- Each digit slot is `SCAN_DIV` cycles long: 1 dead cycle (`Anode`=0000) followed by SCAN_DIV-1 active cycles. The full refresh period is 4*SCAN_DIV cycles.
- `Anode` never has more than one bit set. `Segment` is 00 whenever `Anode`=0000.
- Back-to-back `TICK` pulses on consecutive cycles each count.
- `CLR` held for several cycles keeps `Count` at 0000.

## Test plan
All scenarios use `CLK_FREQ`=400 and `SCAN_HZ`=10, giving `SCAN_DIV`=10.

1. Reset: drive `RST` low asynchronously, mid-slot, with `Count`=0042. Then within the same cycle `Count`=0000, `Anode`=0000, `Segment`=00, `Carry`=0. After release, the first active cycle shows `Anode`=0001, `Segment`=3F.
2. Scan: `Count`=0000, free-run for 40 cycles. `Anode` follows 0000(1 cycle), 0001(9), 0000(1), 0010(9), 0000(1), 0100(9), 0000(1), 1000(9) and repeats. Only the 0001 slot shows 3F; all other slots show 00.
3. Count and blanking: 12 `TICK` pulses with `RUN`=1. Then `Count`=0012; slot 0 shows 5B, slot 1 shows 06, slots 2–3 show 00. Continue to 105 ticks: slot 1 shows 3F and slot 2 shows 06.
4. Gating and priority: 5 ticks with `RUN`=0 leave `Count` unchanged. `TICK` and `CLR` asserted in the same cycle give `Count`=0000 on the next edge.
5. Wrap: 9999 ticks give `Count`=9999 (`Segment` 6F in every slot). One more tick gives `Count`=0000 and `Carry`=1 for exactly one cycle; slots 1–3 then show 00.
6. Back-to-back: 3 consecutive-cycle `TICK` pulses starting from 0008 give 0009, 0010, 0011 on successive cycles, with no digit ever exceeding 9.

Source files
------------

// File: rtl/sec_bcd_display_if.sv
// Bundle of control inputs and display outputs for the seconds counter/display driver.
// The master drives the count controls; the slave (the display block) drives count and display.
interface sec_bcd_display_if;
    logic        TICK;
    logic        RUN;
    logic        CLR;
    logic [15:0] Count;
    logic        Carry;
    logic [3:0]  Anode;
    logic [7:0]  Segment;

    modport master (
        output TICK,
        output RUN,
        output CLR,
        input  Count,
        input  Carry,
        input  Anode,
        input  Segment
    );

    modport slave (
        input  TICK,
        input  RUN,
        input  CLR,
        output Count,
        output Carry,
        output Anode,
        output Segment
    );
endinterface

// File: rtl/sec_bcd_display.sv
// Four-digit BCD seconds counter with a multiplexed, leading-zero-blanked 7-segment driver.
// Each digit slot starts with one dead cycle (all anodes off) to suppress ghosting.
module sec_bcd_display #(
    parameter int unsigned CLK_FREQ = 125_000_000,
    parameter int unsigned SCAN_HZ  = 1000
) (
    input logic              CLK,
    input logic              RST,
    sec_bcd_display_if.slave bus
);

    // SCAN_DIV must be at least 2 so each slot has one active cycle after the dead cycle.
    localparam int unsigned SCAN_DIV = CLK_FREQ / (4 * SCAN_HZ);
    localparam int unsigned PreW     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);

    logic [15:0]     count_q, count_d;
    logic            carry_q, carry_d;
    logic [PreW-1:0] pre_q, pre_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      anode_q, anode_d;
    logic [7:0]      seg_q, seg_d;

    // Scratch signals for the BCD ripple and the blanking decision.
    logic       inc;
    logic [3:0] zero_from;
    logic [3:0] cur_digit;
    logic       blank;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h27;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Count path: clear beats tick; a ripple carries through digits sitting at 9.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        inc     = 1'b0;
        if (bus.CLR) begin
            count_d = 16'h0000;
        end else if (bus.TICK && bus.RUN) begin
            inc = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (inc) begin
                    if (count_q[4*k +: 4] >= 4'd9) begin
                        count_d[4*k +: 4] = 4'd0;
                    end else begin
                        count_d[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                        inc               = 1'b0;
                    end
                end
            end
            carry_d = inc;
        end
    end

    // Scan path: prescaler wraps at SCAN_DIV-1 and steps the digit index.
    always_comb begin
        pre_d = pre_q;
        idx_d = idx_q;
        if (pre_q == PreLast) begin
            pre_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            pre_d = pre_q + PreW'(1);
        end
    end

    // zero_from[k] is set when digits k..3 are all zero.
    always_comb begin
        zero_from[3] = (count_q[15:12] == 4'd0);
        zero_from[2] = zero_from[3] && (count_q[11:8] == 4'd0);
        zero_from[1] = zero_from[2] && (count_q[7:4] == 4'd0);
        zero_from[0] = zero_from[1] && (count_q[3:0] == 4'd0);
    end

    always_comb begin
        cur_digit = 4'd0;
        case (idx_q)
            2'd0:    cur_digit = count_q[3:0];
            2'd1:    cur_digit = count_q[7:4];
            2'd2:    cur_digit = count_q[11:8];
            default: cur_digit = count_q[15:12];
        endcase
        blank = (idx_q != 2'd0) && zero_from[idx_q];
    end

    always_comb begin
        anode_d = 4'b0000;
        seg_d   = 8'h00;
        if (pre_q != '0) begin
            anode_d = 4'b0001 << idx_q;
            seg_d   = blank ? 8'h00 : seg_decode(cur_digit);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= 16'h0000;
            carry_q <= 1'b0;
            pre_q   <= '0;
            idx_q   <= 2'd0;
            anode_q <= 4'b0000;
            seg_q   <= 8'h00;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.Count   = count_q;
    assign bus.Carry   = carry_q;
    assign bus.Anode   = anode_q;
    assign bus.Segment = seg_q;

endmodule
